// File: rtl/gray_arb_pkg.sv
// Shared types and helpers for the Gray-code conversion arbiter.
// Holds the operand width, the output-register state encoding and the Gray function.
package gray_arb_pkg;

    localparam int DATA_W = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    function automatic logic [DATA_W-1:0] to_gray(input logic [DATA_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray_conv_arbiter_if.sv
// Bundle of requester and consumer signals around the shared Gray converter.
// The slave side is the arbiter; the master side drives requests and consumes results.
interface gray_conv_arbiter_if
    import gray_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = 16
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]        req_valid;
    logic [DATA_W*N_REQ-1:0] req_bin;
    logic [N_REQ-1:0]        req_ready;
    logic                    out_valid;
    logic [DATA_W-1:0]       out_gray;
    logic [ID_W-1:0]         out_id;
    logic                    out_ready;
    logic [CNT_W-1:0]        conv_count;

    modport master (
        output req_valid, req_bin, out_ready,
        input  req_ready, out_valid, out_gray, out_id, conv_count
    );

    modport slave (
        input  req_valid, req_bin, out_ready,
        output req_ready, out_valid, out_gray, out_id, conv_count
    );

endinterface

// File: rtl/bin2gray.sv
// Combinational 4-bit binary-to-Gray converter, the shared datapath behind the arbiter.
module bin2gray
    import gray_arb_pkg::*;
(
    input  logic [DATA_W-1:0] bin_i,
    output logic [DATA_W-1:0] gray_o
);

    assign gray_o = to_gray(bin_i);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin picker: scans from the slot after ptr_i, wrapping, and returns the
// first requesting index as a one-hot grant plus its binary index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic          enable_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grantIdx_o,
    output logic          grantValid_o
);

    int idx;

    always_comb begin
        grant_o      = '0;
        grantIdx_o   = '0;
        grantValid_o = 1'b0;
        idx          = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (enable_i && !grantValid_o && req_i[idx]) begin
                grantValid_o = 1'b1;
                grant_o[idx] = 1'b1;
                grantIdx_o   = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Shares one bin2gray converter among N_REQ requesters with round-robin grants and
// a single tagged output register; a new grant may land on the same edge as acceptance.
module gray_conv_arbiter
    import gray_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    gray_conv_arbiter_if.slave bus
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [DATA_W-1:0]  gray_q, gray_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               outValid;
    logic               accept;
    logic               slotFree;
    logic [N_REQ-1:0]   grant;
    logic [ID_W-1:0]    grantIdx;
    logic               grantAny;
    logic [DATA_W-1:0]  operand;
    logic [DATA_W-1:0]  grayNext;

    assign outValid = (state_q == FULL);
    assign accept   = outValid && bus.out_ready;
    assign slotFree = (state_q == EMPTY) || accept;

    rr_arbiter #(.N(N_REQ), .IW(ID_W)) u_rr (
        .req_i        (bus.req_valid),
        .ptr_i        (ptr_q),
        .enable_i     (slotFree && !rst),
        .grant_o      (grant),
        .grantIdx_o   (grantIdx),
        .grantValid_o (grantAny)
    );

    // One-hot grant steers the single operand into the shared converter.
    always_comb begin
        operand = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) operand = bus.req_bin[i*DATA_W +: DATA_W];
        end
    end

    bin2gray u_b2g (
        .bin_i  (operand),
        .gray_o (grayNext)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gray_d  = gray_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        case (state_q)
            EMPTY:   if (grantAny) state_d = FULL;
            FULL:    if (accept && !grantAny) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (grantAny) begin
            ptr_d  = grantIdx;
            gray_d = grayNext;
            id_d   = grantIdx;
        end
        if (accept && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end

    // Pointer starts at the last slot so requester 0 wins the first scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            ptr_q   <= ID_W'(N_REQ - 1);
            gray_q  <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gray_q  <= gray_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.req_ready  = grant;
    assign bus.out_valid  = outValid;
    assign bus.out_gray   = gray_q;
    assign bus.out_id     = id_q;
    assign bus.conv_count = cnt_q;

endmodule

// File: doc/gray_conv_arbiter.md
Name: gray_conv_arbiter

Overview:
Shares one 4-bit bin2gray converter between N_REQ requesters. Grants are round-robin, and each requester uses a valid/ready handshake. Each converted result sits in a single output register with a valid/ready handshake toward the consumer, tagged with the granted requester's index. Sits between producer blocks that need Gray-coded values (counters, pointers) and one shared conversion datapath.

Parameters:
N_REQ, 4, number of requesters (2..8)
CNT_W, 16, width of the conversion counter

Ports:
clk  input  1  clock, all logic on the rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  N_REQ  per-requester request valid
req_bin  input  4*N_REQ  per-requester binary operand; requester i uses bits [4*i+3:4*i]
req_ready  output  N_REQ  one-hot grant/accept; at most one bit high
out_valid  output  1  output register holds a result
out_gray  output  4  Gray-coded result
out_id  output  $clog2(N_REQ)  index of the requester that produced out_gray
out_ready  input  1  consumer accepts result
conv_count  output  CNT_W  total conversions completed (accepted by consumer)

Behaviour:
- Reset (rst=1 at posedge):
  - out_valid=0, out_gray=0, out_id=0, conv_count=0.
  - Round-robin pointer = N_REQ-1, so requester 0 has first priority.
  - FSM to EMPTY.
  - req_ready is 0 while rst=1.
- FSM states:
  - EMPTY: output register free.
  - FULL: output register holds an unaccepted result.
- slot_free = (state==EMPTY) || (out_valid && out_ready). This is combinational; a new grant may occur in the same cycle as consumer acceptance.
- Grant:
  - When slot_free and any req_valid, select the first valid index scanning ptr+1, ptr+2, ... with modulo N_REQ wrap.
  - req_ready[g]=1 in that cycle.
  - The transfer occurs on that edge.
- On a grant edge:
  - out_gray <= bin2gray(req_bin[g]), i.e. b ^ (b>>1).
  - out_id <= g, ptr <= g, state <= FULL.
- Consumer acceptance edge (out_valid && out_ready):
  - With no grant in the same cycle: state <= EMPTY.
  - With a grant in the same cycle: stay FULL with the new data.
- Latency and throughput: 1 cycle from grant to out_valid. Sustained throughput is 1 result per cycle while out_ready=1.
- Stall (FULL && !out_ready):
  - req_ready=0 for all requesters.
  - out_gray and out_id held stable.
  - ptr unchanged.
- Pointer moves only on a grant. With a single active requester, that requester is granted every free cycle. Wrap from N_REQ-1 to 0 is required.
- conv_count increments on each consumer acceptance and saturates at all-ones (no wrap).
- Requesters keep req_valid and req_bin stable until they see req_ready. The arbiter does not check this.
- Reset mid-operation: a pending result is discarded, with no acceptance and no count increment. The first grant after reset goes to requester 0 if it is valid.
- The conversion path is purely combinational between the mux and the output register. No other state is kept.

Decomposition:
- Package gray_arb_pkg holds:
  - DATA_W=4
  - typedef state_t {EMPTY, FULL}
  - function to_gray(logic [DATA_W-1:0])
- Sub-module rr_arbiter (N parameter): inputs req, ptr and enable; outputs one-hot grant and grant index.
- The existing bin2gray module is instantiated once after the operand mux as the shared datapath.

Test Plan:
1. Reset, then only req_valid[0]=1 with bin=4'b1100, out_ready=1 -> req_ready=4'b0001 in the same cycle; next cycle out_valid=1, out_gray=4'b1010, out_id=0; conv_count=1 after acceptance.
2. All four requesters valid with operands 0011, 0110, 1111, 1000, out_ready=1 -> grants in order 0,1,2,3 on consecutive cycles; outputs 0010, 0101, 1000, 1100 back-to-back; then wrap to 0.
3. out_ready=0 for 3 cycles while FULL with out_gray=4'b0100 (operand 0111) -> req_ready=0 throughout, out_gray and out_id stable; on release, acceptance and a new grant happen in the same cycle.
4. Only requester 2 valid for 5 cycles (operand 0001) -> granted every cycle, out_gray=4'b0001, out_id=2 each cycle, conv_count=5.
5. Assert rst while FULL with out_valid=1 -> next cycle out_valid=0, conv_count=0; requesters 1 and 0 both valid after reset -> requester 0 granted first.
6. Force conv_count to saturation (CNT_W=4 build, 17 conversions) -> conv_count stays 4'hF.
